// File: rtl/decode_pkg.sv
// Shared decode constants: opcode/funct/rt fields, ALU-op codes, FSM states.
// No logic; imported by the lookup table, the queue top and the bench.
// Build option ALU_DECODE_TRAP_EN only affects alu_op_lut, not this package.
package decode_pkg;

  localparam int ALU_OP_W = 8;

  typedef enum logic [0:0] {
    RUN      = 1'b0,
    EXC_HOLD = 1'b1
  } state_t;

  // Whole-word and prefix forms for the CP0 instructions
  localparam logic [31:0] INSTR_ERET = 32'h4200_0018;
  localparam logic [10:0] PFX_MTC0   = 11'b010_0000_0100;
  localparam logic [10:0] PFX_MFC0   = 11'b010_0000_0000;

  // Primary opcodes
  localparam logic [5:0] OPC_SPECIAL = 6'b000000;
  localparam logic [5:0] OPC_REGIMM  = 6'b000001;
  localparam logic [5:0] OPC_J       = 6'b000010;
  localparam logic [5:0] OPC_JAL     = 6'b000011;
  localparam logic [5:0] OPC_BEQ     = 6'b000100;
  localparam logic [5:0] OPC_BNE     = 6'b000101;
  localparam logic [5:0] OPC_BLEZ    = 6'b000110;
  localparam logic [5:0] OPC_BGTZ    = 6'b000111;
  localparam logic [5:0] OPC_ADDI    = 6'b001000;
  localparam logic [5:0] OPC_ADDIU   = 6'b001001;
  localparam logic [5:0] OPC_SLTI    = 6'b001010;
  localparam logic [5:0] OPC_SLTIU   = 6'b001011;
  localparam logic [5:0] OPC_ANDI    = 6'b001100;
  localparam logic [5:0] OPC_ORI     = 6'b001101;
  localparam logic [5:0] OPC_XORI    = 6'b001110;
  localparam logic [5:0] OPC_LUI     = 6'b001111;
  localparam logic [5:0] OPC_LB      = 6'b100000;
  localparam logic [5:0] OPC_LH      = 6'b100001;
  localparam logic [5:0] OPC_LW      = 6'b100011;
  localparam logic [5:0] OPC_LBU     = 6'b100100;
  localparam logic [5:0] OPC_LHU     = 6'b100101;
  localparam logic [5:0] OPC_SB      = 6'b101000;
  localparam logic [5:0] OPC_SH      = 6'b101001;
  localparam logic [5:0] OPC_SW      = 6'b101011;

  // SPECIAL funct values
  localparam logic [5:0] FN_SLL     = 6'b000000;
  localparam logic [5:0] FN_SRL     = 6'b000010;
  localparam logic [5:0] FN_SRA     = 6'b000011;
  localparam logic [5:0] FN_SLLV    = 6'b000100;
  localparam logic [5:0] FN_SRLV    = 6'b000110;
  localparam logic [5:0] FN_SRAV    = 6'b000111;
  localparam logic [5:0] FN_JR      = 6'b001000;
  localparam logic [5:0] FN_JALR    = 6'b001001;
  localparam logic [5:0] FN_MOVZ    = 6'b001010;
  localparam logic [5:0] FN_MOVN    = 6'b001011;
  localparam logic [5:0] FN_SYSCALL = 6'b001100;
  localparam logic [5:0] FN_BREAK   = 6'b001101;
  localparam logic [5:0] FN_MFHI    = 6'b010000;
  localparam logic [5:0] FN_MTHI    = 6'b010001;
  localparam logic [5:0] FN_MFLO    = 6'b010010;
  localparam logic [5:0] FN_MTLO    = 6'b010011;
  localparam logic [5:0] FN_MULT    = 6'b011000;
  localparam logic [5:0] FN_MULTU   = 6'b011001;
  localparam logic [5:0] FN_DIV     = 6'b011010;
  localparam logic [5:0] FN_DIVU    = 6'b011011;
  localparam logic [5:0] FN_ADD     = 6'b100000;
  localparam logic [5:0] FN_ADDU    = 6'b100001;
  localparam logic [5:0] FN_SUB     = 6'b100010;
  localparam logic [5:0] FN_SUBU    = 6'b100011;
  localparam logic [5:0] FN_AND     = 6'b100100;
  localparam logic [5:0] FN_OR      = 6'b100101;
  localparam logic [5:0] FN_XOR     = 6'b100110;
  localparam logic [5:0] FN_NOR     = 6'b100111;
  localparam logic [5:0] FN_SLT     = 6'b101010;
  localparam logic [5:0] FN_SLTU    = 6'b101011;
  localparam logic [5:0] FN_TGE     = 6'b110000;
  localparam logic [5:0] FN_TGEU    = 6'b110001;
  localparam logic [5:0] FN_TLT     = 6'b110010;
  localparam logic [5:0] FN_TLTU    = 6'b110011;
  localparam logic [5:0] FN_TEQ     = 6'b110100;
  localparam logic [5:0] FN_TNE     = 6'b110110;

  // REGIMM rt values
  localparam logic [4:0] RT_BLTZ   = 5'b00000;
  localparam logic [4:0] RT_BGEZ   = 5'b00001;
  localparam logic [4:0] RT_BLTZAL = 5'b10000;
  localparam logic [4:0] RT_BGEZAL = 5'b10001;

  // ALU-op codes (all non-zero; zero is reserved for "no decode")
  localparam logic [ALU_OP_W-1:0] EXE_SLLV_OP    = 8'b0000_0100;
  localparam logic [ALU_OP_W-1:0] EXE_SRL_OP     = 8'b0000_0010;
  localparam logic [ALU_OP_W-1:0] EXE_SRA_OP     = 8'b0000_0011;
  localparam logic [ALU_OP_W-1:0] EXE_SRLV_OP    = 8'b0000_0110;
  localparam logic [ALU_OP_W-1:0] EXE_SRAV_OP    = 8'b0000_0111;
  localparam logic [ALU_OP_W-1:0] EXE_JR_OP      = 8'b0000_1000;
  localparam logic [ALU_OP_W-1:0] EXE_JALR_OP    = 8'b0000_1001;
  localparam logic [ALU_OP_W-1:0] EXE_MOVZ_OP    = 8'b0000_1010;
  localparam logic [ALU_OP_W-1:0] EXE_MOVN_OP    = 8'b0000_1011;
  localparam logic [ALU_OP_W-1:0] EXE_SYSCALL_OP = 8'b0000_1100;
  localparam logic [ALU_OP_W-1:0] EXE_BREAK_OP   = 8'b0000_1101;
  localparam logic [ALU_OP_W-1:0] EXE_MFHI_OP    = 8'b0001_0000;
  localparam logic [ALU_OP_W-1:0] EXE_MTHI_OP    = 8'b0001_0001;
  localparam logic [ALU_OP_W-1:0] EXE_MFLO_OP    = 8'b0001_0010;
  localparam logic [ALU_OP_W-1:0] EXE_MTLO_OP    = 8'b0001_0011;
  localparam logic [ALU_OP_W-1:0] EXE_MULT_OP    = 8'b0001_1000;
  localparam logic [ALU_OP_W-1:0] EXE_MULTU_OP   = 8'b0001_1001;
  localparam logic [ALU_OP_W-1:0] EXE_DIV_OP     = 8'b0001_1010;
  localparam logic [ALU_OP_W-1:0] EXE_DIVU_OP    = 8'b0001_1011;
  localparam logic [ALU_OP_W-1:0] EXE_ADD_OP     = 8'b0010_0000;
  localparam logic [ALU_OP_W-1:0] EXE_ADDU_OP    = 8'b0010_0001;
  localparam logic [ALU_OP_W-1:0] EXE_SUB_OP     = 8'b0010_0010;
  localparam logic [ALU_OP_W-1:0] EXE_SUBU_OP    = 8'b0010_0011;
  localparam logic [ALU_OP_W-1:0] EXE_AND_OP     = 8'b0010_0100;
  localparam logic [ALU_OP_W-1:0] EXE_OR_OP      = 8'b0010_0101;
  localparam logic [ALU_OP_W-1:0] EXE_XOR_OP     = 8'b0010_0110;
  localparam logic [ALU_OP_W-1:0] EXE_NOR_OP     = 8'b0010_0111;
  localparam logic [ALU_OP_W-1:0] EXE_SLT_OP     = 8'b0010_1010;
  localparam logic [ALU_OP_W-1:0] EXE_SLTU_OP    = 8'b0010_1011;
  localparam logic [ALU_OP_W-1:0] EXE_TGE_OP     = 8'b0011_0000;
  localparam logic [ALU_OP_W-1:0] EXE_TGEU_OP    = 8'b0011_0001;
  localparam logic [ALU_OP_W-1:0] EXE_TLT_OP     = 8'b0011_0010;
  localparam logic [ALU_OP_W-1:0] EXE_TLTU_OP    = 8'b0011_0011;
  localparam logic [ALU_OP_W-1:0] EXE_TEQ_OP     = 8'b0011_0100;
  localparam logic [ALU_OP_W-1:0] EXE_TNE_OP     = 8'b0011_0110;
  localparam logic [ALU_OP_W-1:0] EXE_BLTZ_OP    = 8'b0100_0000;
  localparam logic [ALU_OP_W-1:0] EXE_BGEZ_OP    = 8'b0100_0001;
  localparam logic [ALU_OP_W-1:0] EXE_BLTZAL_OP  = 8'b0100_1010;
  localparam logic [ALU_OP_W-1:0] EXE_BGEZAL_OP  = 8'b0100_1011;
  localparam logic [ALU_OP_W-1:0] EXE_J_OP       = 8'b0100_1111;
  localparam logic [ALU_OP_W-1:0] EXE_JAL_OP     = 8'b0101_0000;
  localparam logic [ALU_OP_W-1:0] EXE_BEQ_OP     = 8'b0101_0001;
  localparam logic [ALU_OP_W-1:0] EXE_BNE_OP     = 8'b0101_0010;
  localparam logic [ALU_OP_W-1:0] EXE_BLEZ_OP    = 8'b0101_0011;
  localparam logic [ALU_OP_W-1:0] EXE_BGTZ_OP    = 8'b0101_0100;
  localparam logic [ALU_OP_W-1:0] EXE_ADDI_OP    = 8'b0101_0101;
  localparam logic [ALU_OP_W-1:0] EXE_ADDIU_OP   = 8'b0101_0110;
  localparam logic [ALU_OP_W-1:0] EXE_SLTI_OP    = 8'b0101_0111;
  localparam logic [ALU_OP_W-1:0] EXE_SLTIU_OP   = 8'b0101_1000;
  localparam logic [ALU_OP_W-1:0] EXE_ANDI_OP    = 8'b0101_1001;
  localparam logic [ALU_OP_W-1:0] EXE_ORI_OP     = 8'b0101_1010;
  localparam logic [ALU_OP_W-1:0] EXE_XORI_OP    = 8'b0101_1011;
  localparam logic [ALU_OP_W-1:0] EXE_LUI_OP     = 8'b0101_1100;
  localparam logic [ALU_OP_W-1:0] EXE_MFC0_OP    = 8'b0101_1101;
  localparam logic [ALU_OP_W-1:0] EXE_MTC0_OP    = 8'b0110_0000;
  localparam logic [ALU_OP_W-1:0] EXE_ERET_OP    = 8'b0110_1011;
  localparam logic [ALU_OP_W-1:0] EXE_SLL_OP     = 8'b0111_1100;
  localparam logic [ALU_OP_W-1:0] EXE_LB_OP      = 8'b1110_0000;
  localparam logic [ALU_OP_W-1:0] EXE_LH_OP      = 8'b1110_0001;
  localparam logic [ALU_OP_W-1:0] EXE_LW_OP      = 8'b1110_0011;
  localparam logic [ALU_OP_W-1:0] EXE_LBU_OP     = 8'b1110_0100;
  localparam logic [ALU_OP_W-1:0] EXE_LHU_OP     = 8'b1110_0101;
  localparam logic [ALU_OP_W-1:0] EXE_SB_OP      = 8'b1110_1000;
  localparam logic [ALU_OP_W-1:0] EXE_SH_OP      = 8'b1110_1001;
  localparam logic [ALU_OP_W-1:0] EXE_SW_OP      = 8'b1110_1011;

endpackage

// File: rtl/alu_op_lut.sv
// Instruction word -> {hit, ALU-op code} priority decoder, purely combinational.
// Latency: zero cycles. Backpressure: none (no state, no handshake).
// Build option: ALU_DECODE_TRAP_EN decodes the SPECIAL trap functs instead of flagging them reserved.
module alu_op_lut
  import decode_pkg::*;
(
  input  logic [31:0]         i_instr,
  output logic                o_hit,
  output logic [ALU_OP_W-1:0] o_alucontrol
);

  logic [5:0] w_opcode;
  logic [5:0] w_funct;
  logic [4:0] w_rt;

  assign w_opcode = i_instr[31:26];
  assign w_funct  = i_instr[5:0];
  assign w_rt     = i_instr[20:16];

  // Priority chain: CP0 forms, then SPECIAL funct, REGIMM rt, primary opcode; any miss leaves hit=0, code=0
  always_comb begin
    o_hit        = 1'b0;
    o_alucontrol = '0;
    if (i_instr == INSTR_ERET) begin
      o_hit        = 1'b1;
      o_alucontrol = EXE_ERET_OP;
    end else if (i_instr[31:21] == PFX_MTC0) begin
      o_hit        = 1'b1;
      o_alucontrol = EXE_MTC0_OP;
    end else if (i_instr[31:21] == PFX_MFC0) begin
      o_hit        = 1'b1;
      o_alucontrol = EXE_MFC0_OP;
    end else if (w_opcode == OPC_SPECIAL) begin
      o_hit = 1'b1;
      case (w_funct)
        FN_SLL:     o_alucontrol = EXE_SLL_OP;
        FN_SRL:     o_alucontrol = EXE_SRL_OP;
        FN_SRA:     o_alucontrol = EXE_SRA_OP;
        FN_SLLV:    o_alucontrol = EXE_SLLV_OP;
        FN_SRLV:    o_alucontrol = EXE_SRLV_OP;
        FN_SRAV:    o_alucontrol = EXE_SRAV_OP;
        FN_JR:      o_alucontrol = EXE_JR_OP;
        FN_JALR:    o_alucontrol = EXE_JALR_OP;
        FN_MOVZ:    o_alucontrol = EXE_MOVZ_OP;
        FN_MOVN:    o_alucontrol = EXE_MOVN_OP;
        FN_SYSCALL: o_alucontrol = EXE_SYSCALL_OP;
        FN_BREAK:   o_alucontrol = EXE_BREAK_OP;
        FN_MFHI:    o_alucontrol = EXE_MFHI_OP;
        FN_MTHI:    o_alucontrol = EXE_MTHI_OP;
        FN_MFLO:    o_alucontrol = EXE_MFLO_OP;
        FN_MTLO:    o_alucontrol = EXE_MTLO_OP;
        FN_MULT:    o_alucontrol = EXE_MULT_OP;
        FN_MULTU:   o_alucontrol = EXE_MULTU_OP;
        FN_DIV:     o_alucontrol = EXE_DIV_OP;
        FN_DIVU:    o_alucontrol = EXE_DIVU_OP;
        FN_ADD:     o_alucontrol = EXE_ADD_OP;
        FN_ADDU:    o_alucontrol = EXE_ADDU_OP;
        FN_SUB:     o_alucontrol = EXE_SUB_OP;
        FN_SUBU:    o_alucontrol = EXE_SUBU_OP;
        FN_AND:     o_alucontrol = EXE_AND_OP;
        FN_OR:      o_alucontrol = EXE_OR_OP;
        FN_XOR:     o_alucontrol = EXE_XOR_OP;
        FN_NOR:     o_alucontrol = EXE_NOR_OP;
        FN_SLT:     o_alucontrol = EXE_SLT_OP;
        FN_SLTU:    o_alucontrol = EXE_SLTU_OP;
`ifdef ALU_DECODE_TRAP_EN
        FN_TGE:     o_alucontrol = EXE_TGE_OP;
        FN_TGEU:    o_alucontrol = EXE_TGEU_OP;
        FN_TLT:     o_alucontrol = EXE_TLT_OP;
        FN_TLTU:    o_alucontrol = EXE_TLTU_OP;
        FN_TEQ:     o_alucontrol = EXE_TEQ_OP;
        FN_TNE:     o_alucontrol = EXE_TNE_OP;
`endif
        default:    o_hit = 1'b0;
      endcase
    end else if (w_opcode == OPC_REGIMM) begin
      o_hit = 1'b1;
      case (w_rt)
        RT_BLTZ:   o_alucontrol = EXE_BLTZ_OP;
        RT_BGEZ:   o_alucontrol = EXE_BGEZ_OP;
        RT_BLTZAL: o_alucontrol = EXE_BLTZAL_OP;
        RT_BGEZAL: o_alucontrol = EXE_BGEZAL_OP;
        default:   o_hit = 1'b0;
      endcase
    end else begin
      o_hit = 1'b1;
      case (w_opcode)
        OPC_J:     o_alucontrol = EXE_J_OP;
        OPC_JAL:   o_alucontrol = EXE_JAL_OP;
        OPC_BEQ:   o_alucontrol = EXE_BEQ_OP;
        OPC_BNE:   o_alucontrol = EXE_BNE_OP;
        OPC_BLEZ:  o_alucontrol = EXE_BLEZ_OP;
        OPC_BGTZ:  o_alucontrol = EXE_BGTZ_OP;
        OPC_ADDI:  o_alucontrol = EXE_ADDI_OP;
        OPC_ADDIU: o_alucontrol = EXE_ADDIU_OP;
        OPC_SLTI:  o_alucontrol = EXE_SLTI_OP;
        OPC_SLTIU: o_alucontrol = EXE_SLTIU_OP;
        OPC_ANDI:  o_alucontrol = EXE_ANDI_OP;
        OPC_ORI:   o_alucontrol = EXE_ORI_OP;
        OPC_XORI:  o_alucontrol = EXE_XORI_OP;
        OPC_LUI:   o_alucontrol = EXE_LUI_OP;
        OPC_LB:    o_alucontrol = EXE_LB_OP;
        OPC_LH:    o_alucontrol = EXE_LH_OP;
        OPC_LW:    o_alucontrol = EXE_LW_OP;
        OPC_LBU:   o_alucontrol = EXE_LBU_OP;
        OPC_LHU:   o_alucontrol = EXE_LHU_OP;
        OPC_SB:    o_alucontrol = EXE_SB_OP;
        OPC_SH:    o_alucontrol = EXE_SH_OP;
        OPC_SW:    o_alucontrol = EXE_SW_OP;
        default:   o_hit = 1'b0;
      endcase
    end
  end

endmodule

// File: rtl/alu_decode_queue.sv
// Buffered ALU-control decoder: DEPTH-entry {pc,instr} FIFO feeding a registered decode output stage.
// Latency: push at edge N into an empty queue presents out_valid after edge N+1; 1 instr/cycle sustained.
// Backpressure: in_ready drops when FIFO full or in exception hold; output held stable while !out_ready.
// Build option: ALU_DECODE_TRAP_EN (passed through to alu_op_lut; enables trap functs).
module alu_decode_queue
  import decode_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int OP_W  = ALU_OP_W,
  parameter int PC_W  = 32
) (
  input  logic                   clk,
  input  logic                   resetn,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [31:0]            in_instr,
  input  logic [PC_W-1:0]        in_pc,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [OP_W-1:0]        out_alucontrol,
  output logic [31:0]            out_instr,
  output logic [PC_W-1:0]        out_pc,
  output logic                   out_invalid,
  input  logic                   flush,
  output logic [$clog2(DEPTH):0] count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

  logic [31:0]     r_mem_instr [DEPTH];
  logic [PC_W-1:0] r_mem_pc    [DEPTH];
  logic [AW-1:0]   r_wr_ptr;
  logic [AW-1:0]   r_rd_ptr;
  logic [CW-1:0]   r_count;

  logic            r_out_valid;
  logic [OP_W-1:0] r_out_alucontrol;
  logic [31:0]     r_out_instr;
  logic [PC_W-1:0] r_out_pc;
  logic            r_out_invalid;

  state_t          r_state;
  state_t          w_state_nxt;
  logic            w_run_ready;

  logic            w_push;
  logic            w_load;
  logic [31:0]     w_head_instr;
  logic            w_lut_hit;
  logic [ALU_OP_W-1:0] w_lut_code;

  assign w_head_instr = r_mem_instr[r_rd_ptr];

  alu_op_lut u_lut (
    .i_instr      (w_head_instr),
    .o_hit        (w_lut_hit),
    .o_alucontrol (w_lut_code)
  );

  // in_ready is forced low while reset is held, independent of register state
  assign in_ready = resetn & w_run_ready;
  assign w_push   = in_valid & in_ready;
  assign w_load   = (r_count != '0) & (r_state == RUN) & (!r_out_valid | out_ready);

  assign out_valid      = r_out_valid;
  assign out_alucontrol = r_out_alucontrol;
  assign out_instr      = r_out_instr;
  assign out_pc         = r_out_pc;
  assign out_invalid    = r_out_invalid;
  assign count          = r_count;

  // FIFO storage write; no reset needed since pointers define what is live
  always_ff @(posedge clk) begin
    if (w_push && !flush) begin
      r_mem_instr[r_wr_ptr] <= in_instr;
      r_mem_pc[r_wr_ptr]    <= in_pc;
    end
  end

  // Pointers and occupancy; flush wins over a simultaneous push/pop
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else if (flush) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_load) r_rd_ptr <= r_rd_ptr + 1'b1;
      case ({w_push, w_load})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  // Registered output stage: load decoded head, hold while stalled, drop valid on accept
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_out_valid      <= 1'b0;
      r_out_alucontrol <= '0;
      r_out_instr      <= '0;
      r_out_pc         <= '0;
      r_out_invalid    <= 1'b0;
    end else if (flush) begin
      r_out_valid   <= 1'b0;
      r_out_invalid <= 1'b0;
    end else if (w_load) begin
      r_out_valid      <= 1'b1;
      r_out_alucontrol <= OP_W'(w_lut_code);
      r_out_instr      <= w_head_instr;
      r_out_pc         <= r_mem_pc[r_rd_ptr];
      r_out_invalid    <= ~w_lut_hit;
    end else if (r_out_valid && out_ready) begin
      r_out_valid <= 1'b0;
    end
  end

  // FSM state register
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_state <= RUN;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // FSM next state and input readiness; a reserved entry entering the output stage freezes the queue
  always_comb begin
    w_state_nxt = r_state;
    w_run_ready = 1'b0;
    case (r_state)
      RUN: begin
        w_run_ready = (r_count < FULL_CNT);
        if (w_load && !w_lut_hit) begin
          w_state_nxt = EXC_HOLD;
        end
      end
      EXC_HOLD: begin
        w_run_ready = 1'b0;
      end
      default: begin
        w_state_nxt = RUN;
      end
    endcase
    if (flush) begin
      w_state_nxt = RUN;
    end
  end

endmodule

// File: tb/tb_alu_decode_queue.sv
// Scoreboard bench for alu_decode_queue: directed pushes queue expected outputs,
// a negedge monitor pops and compares on every accepted output handshake.
module tb_alu_decode_queue;

  localparam int DEPTH = 4;
  localparam int OP_W  = 8;
  localparam int PC_W  = 32;

`ifdef ALU_DECODE_TRAP_EN
  localparam bit TRAP = 1'b1;
`else
  localparam bit TRAP = 1'b0;
`endif

  logic            clk = 1'b0;
  logic            resetn;
  logic            in_valid;
  logic            in_ready;
  logic [31:0]     in_instr;
  logic [PC_W-1:0] in_pc;
  logic            out_valid;
  logic            out_ready;
  logic [OP_W-1:0] out_alucontrol;
  logic [31:0]     out_instr;
  logic [PC_W-1:0] out_pc;
  logic            out_invalid;
  logic            flush;
  logic [2:0]      count;

  typedef struct packed {
    logic [7:0]  code;
    logic [31:0] instr;
    logic [31:0] pc;
    logic        inv;
  } exp_t;

  exp_t sb[$];
  int checks   = 0;
  int failures = 0;

  alu_decode_queue #(.DEPTH(DEPTH), .OP_W(OP_W), .PC_W(PC_W)) dut (
    .clk            (clk),
    .resetn         (resetn),
    .in_valid       (in_valid),
    .in_ready       (in_ready),
    .in_instr       (in_instr),
    .in_pc          (in_pc),
    .out_valid      (out_valid),
    .out_ready      (out_ready),
    .out_alucontrol (out_alucontrol),
    .out_instr      (out_instr),
    .out_pc         (out_pc),
    .out_invalid    (out_invalid),
    .flush          (flush),
    .count          (count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // Monitor: every accepted output must match the oldest expected entry
  always @(negedge clk) begin
    exp_t e;
    if (resetn && !flush && out_valid && out_ready) begin
      if (sb.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_output actual_instr=%0h required=none", out_instr);
      end else begin
        e = sb.pop_front();
        chk("sb_alucontrol", 64'(out_alucontrol), 64'(e.code));
        chk("sb_instr", 64'(out_instr), 64'(e.instr));
        chk("sb_pc", 64'(out_pc), 64'(e.pc));
        chk("sb_invalid", 64'(out_invalid), 64'(e.inv));
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Present one instruction until accepted; queue its expected output if it should appear
  task automatic push(input logic [31:0] instr, input logic [31:0] pc,
                      input logic [7:0] code, input logic inv, input bit expect_out);
    int  n;
    bit  done;
    exp_t e;
    n    = 0;
    done = 1'b0;
    in_valid = 1'b1;
    in_instr = instr;
    in_pc    = pc;
    while (!done) begin
      @(negedge clk);
      if (in_ready) begin
        done = 1'b1;
        if (expect_out) begin
          e.code  = code;
          e.instr = instr;
          e.pc    = pc;
          e.inv   = inv;
          sb.push_back(e);
        end
      end
      tick();
      n++;
      if (!done && n > 50) begin
        checks++;
        failures++;
        $display("FAIL push_timeout actual=no_in_ready required=accept instr=%0h", instr);
        done = 1'b1;
      end
    end
    in_valid = 1'b0;
  endtask

  // Wait until the scoreboard is drained and the block is idle, bounded
  task automatic wait_drain(input string name);
    int n;
    n = 0;
    while ((sb.size() != 0 || out_valid || count != 0) && n < 60) begin
      tick();
      n++;
    end
    checks++;
    if (n >= 60) begin
      failures++;
      $display("FAIL %s drain_timeout actual_pending=%0d required=0", name, sb.size());
    end
  endtask

  initial begin
    #200000;
    failures++;
    $display("FAIL watchdog actual=timeout required=finish");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $fatal(1, "watchdog");
  end

  initial begin
    int seen;
    resetn    = 1'b0;
    in_valid  = 1'b0;
    in_instr  = '0;
    in_pc     = '0;
    out_ready = 1'b0;
    flush     = 1'b0;

    // Reset state
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_alucontrol", 64'(out_alucontrol), 64'd0);
    chk("rst_instr", 64'(out_instr), 64'd0);
    chk("rst_pc", 64'(out_pc), 64'd0);
    chk("rst_invalid", 64'(out_invalid), 64'd0);
    chk("rst_count", 64'(count), 64'd0);
    chk("rst_in_ready", 64'(in_ready), 64'd0);
    resetn = 1'b1;
    tick();
    chk("post_rst_in_ready", 64'(in_ready), 64'd1);

    // Single addu: two-cycle latency
    out_ready = 1'b1;
    push(32'h0022_1821, 32'h0000_1000, 8'h21, 1'b0, 1'b1);
    chk("lat_valid_edgeN", 64'(out_valid), 64'd0);
    tick();
    chk("lat_valid_edgeN1", 64'(out_valid), 64'd1);
    wait_drain("single_addu");

    // Fill to capacity with consumer stalled, then drain in order
    out_ready = 1'b0;
    push(32'h0022_1821, 32'h0000_2000, 8'h21, 1'b0, 1'b1);
    push(32'h3421_0005, 32'h0000_2004, 8'h5A, 1'b0, 1'b1);
    push(32'h8C22_0004, 32'h0000_2008, 8'hE3, 1'b0, 1'b1);
    push(32'h0411_0003, 32'h0000_200C, 8'h4B, 1'b0, 1'b1);
    push(32'h0022_1825, 32'h0000_2010, 8'h25, 1'b0, 1'b1);
    @(negedge clk);
    chk("full_count", 64'(count), 64'd4);
    chk("full_in_ready", 64'(in_ready), 64'd0);
    chk("full_out_valid", 64'(out_valid), 64'd1);
    chk("full_head_instr", 64'(out_instr), 64'h0022_1821);
    tick();
    out_ready = 1'b1;
    seen = 0;
    repeat (5) begin
      @(negedge clk);
      if (out_valid) seen++;
    end
    chk("drain_throughput", 64'(seen), 64'd5);
    wait_drain("fill_drain");

    // Reserved instruction: exception hold until flush
    out_ready = 1'b0;
    push(32'hFC00_0000, 32'h0000_3000, 8'h00, 1'b1, 1'b1);
    push(32'h0022_1821, 32'h0000_3004, 8'h21, 1'b0, 1'b0);
    @(negedge clk);
    chk("exc_in_ready", 64'(in_ready), 64'd0);
    chk("exc_out_valid", 64'(out_valid), 64'd1);
    chk("exc_out_invalid", 64'(out_invalid), 64'd1);
    chk("exc_alucontrol", 64'(out_alucontrol), 64'd0);
    chk("exc_count", 64'(count), 64'd1);
    tick();
    out_ready = 1'b1;
    tick();
    repeat (4) begin
      @(negedge clk);
      chk("exc_hold_no_output", 64'(out_valid), 64'd0);
    end
    chk("exc_hold_in_ready", 64'(in_ready), 64'd0);
    chk("exc_hold_count", 64'(count), 64'd1);
    tick();
    flush = 1'b1;
    tick();
    flush = 1'b0;
    @(negedge clk);
    chk("exc_flush_count", 64'(count), 64'd0);
    chk("exc_flush_in_ready", 64'(in_ready), 64'd1);
    chk("exc_flush_invalid", 64'(out_invalid), 64'd0);
    chk("exc_flush_valid", 64'(out_valid), 64'd0);

    // Flush coinciding with push and pop at count=2
    tick();
    out_ready = 1'b0;
    push(32'h0022_1821, 32'h0000_4000, 8'h21, 1'b0, 1'b0);
    push(32'h3421_0005, 32'h0000_4004, 8'h5A, 1'b0, 1'b0);
    push(32'h8C22_0004, 32'h0000_4008, 8'hE3, 1'b0, 1'b0);
    @(negedge clk);
    chk("fl_pre_count", 64'(count), 64'd2);
    tick();
    in_valid  = 1'b1;
    in_instr  = 32'h0022_1825;
    in_pc     = 32'h0000_400C;
    out_ready = 1'b1;
    flush     = 1'b1;
    @(negedge clk);
    chk("fl_push_offered", 64'(in_ready), 64'd1);
    chk("fl_pop_offered", 64'(out_valid), 64'd1);
    tick();
    in_valid = 1'b0;
    flush    = 1'b0;
    @(negedge clk);
    chk("fl_count", 64'(count), 64'd0);
    chk("fl_out_valid", 64'(out_valid), 64'd0);
    repeat (3) begin
      @(negedge clk);
      chk("fl_word_dropped", 64'(out_valid), 64'd0);
    end

    // Trap funct: decoded only when the trap option is built in
    tick();
    out_ready = 1'b1;
    if (TRAP) push(32'h0022_0034, 32'h0000_5000, 8'h34, 1'b0, 1'b1);
    else      push(32'h0022_0034, 32'h0000_5000, 8'h00, 1'b1, 1'b1);
    wait_drain("teq");
    chk("teq_in_ready", 64'(in_ready), TRAP ? 64'd1 : 64'd0);
    tick();
    flush = 1'b1;
    tick();
    flush = 1'b0;

    // CP0 forms
    push(32'h4200_0018, 32'h0000_6000, 8'h6B, 1'b0, 1'b1);
    push(32'h4080_6000, 32'h0000_6004, 8'h60, 1'b0, 1'b1);
    wait_drain("cp0");

    // Asynchronous reset mid-stream
    out_ready = 1'b0;
    push(32'h0022_1821, 32'h0000_7000, 8'h21, 1'b0, 1'b0);
    push(32'h3421_0005, 32'h0000_7004, 8'h5A, 1'b0, 1'b0);
    @(negedge clk);
    chk("pre_areset_valid", 64'(out_valid), 64'd1);
    #2;
    resetn = 1'b0;
    #1;
    chk("areset_out_valid", 64'(out_valid), 64'd0);
    chk("areset_alucontrol", 64'(out_alucontrol), 64'd0);
    chk("areset_instr", 64'(out_instr), 64'd0);
    chk("areset_pc", 64'(out_pc), 64'd0);
    chk("areset_invalid", 64'(out_invalid), 64'd0);
    chk("areset_count", 64'(count), 64'd0);
    chk("areset_in_ready", 64'(in_ready), 64'd0);
    @(negedge clk);
    resetn = 1'b1;
    tick();
    @(negedge clk);
    chk("post_areset_valid", 64'(out_valid), 64'd0);
    chk("post_areset_in_ready", 64'(in_ready), 64'd1);

    chk("sb_empty", 64'(sb.size()), 64'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
